// File: rtl/sha256_mem_responder.sv
// ============================================================================
//  Module      : sha256_mem_responder
//  Description : Word RAM, loader and host sequencer for the SHA-256 hasher's
//                memory port; streams the 8-word digest out after each hash.
//                Optional watchdog enabled by defining SHA_RESP_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_mem_responder #(
    parameter int unsigned NUM_WORDS      = 20,
    parameter int unsigned DEPTH          = 64,
    parameter int unsigned MSG_BASE       = 0,
    parameter int unsigned HASH_BASE      = 32
`ifdef SHA_RESP_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic        busy,
    output logic        error,
    output logic        sha_start,
    input  logic        sha_done,
    output logic [15:0] sha_input_addr,
    output logic [15:0] sha_hash_addr,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata
);

    localparam int unsigned     AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CW         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [15:0]     C_DEPTH    = 16'(DEPTH);
    localparam logic [15:0]     C_HASH_LO  = 16'(HASH_BASE);
    localparam logic [15:0]     C_HASH_HI  = 16'(HASH_BASE + 7);
    localparam logic [AW-1:0]   C_MSG_A    = AW'(MSG_BASE);
    localparam logic [AW-1:0]   C_HASH_A   = AW'(HASH_BASE);
    localparam logic [CW-1:0]   C_CNT_LAST = CW'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_START = 3'd1,
        S_ARM   = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      rd_idx_q, rd_idx_d;
    logic            s_ready_q;
    logic            m_valid_q, m_valid_d;
    logic [31:0]     m_data_q;
    logic [31:0]     mem_rdata_q;
    logic [31:0]     ram_q [DEPTH];

    logic            w_load_hs;
    logic            w_hash_we;
    logic            w_fetch;
    logic            w_timeout;

    assign w_load_hs = (state_q == S_LOAD) && s_ready_q && s_valid;
    assign w_hash_we = (state_q == S_RUN) && mem_we &&
                       (mem_addr >= C_HASH_LO) && (mem_addr <= C_HASH_HI);
    assign w_fetch   = (state_q == S_DRAIN) && !m_valid_q;

`ifdef SHA_RESP_TIMEOUT_EN
    localparam logic [15:0] C_WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wdog_q;
    logic        error_q;

    assign w_timeout = ((state_q == S_ARM) || (state_q == S_RUN)) && (wdog_q == C_WDOG_LAST);

    // START is the only way into ARM, so clearing there restarts the count on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q  <= '0;
            error_q <= 1'b0;
        end else begin
            if (state_q == S_START) begin
                wdog_q <= '0;
            end else if ((state_q == S_ARM) || (state_q == S_RUN)) begin
                wdog_q <= wdog_q + 16'd1;
            end
            if (w_timeout) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error = error_q;
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_idx_d  = rd_idx_q;
        m_valid_d = m_valid_q;
        sha_start = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (w_load_hs) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == C_CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                sha_start = 1'b1;
                state_d   = S_ARM;
            end
            S_ARM: begin
                if (!sha_done) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (sha_done) begin
                    state_d  = S_DRAIN;
                    rd_idx_d = 3'd0;
                end
            end
            S_DRAIN: begin
                // Alternates fetch and present, so at most one word every two cycles.
                if (w_fetch) begin
                    m_valid_d = 1'b1;
                end else if (m_ready) begin
                    m_valid_d = 1'b0;
                    rd_idx_d  = rd_idx_q + 3'd1;
                    if (rd_idx_q == 3'd7) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
        if (w_timeout) begin
            state_d   = S_LOAD;
            cnt_d     = '0;
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            rd_idx_q    <= 3'd0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_idx_q    <= rd_idx_d;
            s_ready_q   <= (state_d == S_LOAD);
            m_valid_q   <= m_valid_d;
            if (w_fetch) begin
                m_data_q <= ram_q[C_HASH_A + AW'(rd_idx_q)];
            end
            mem_rdata_q <= (mem_addr < C_DEPTH) ? ram_q[mem_addr[AW-1:0]] : 32'd0;
        end
    end

    // RAM is deliberately left out of reset; loader and hasher writes never overlap in state.
    always_ff @(posedge clk) begin
        if (w_load_hs) begin
            ram_q[C_MSG_A + AW'(cnt_q)] <= s_data;
        end else if (w_hash_we) begin
            ram_q[mem_addr[AW-1:0]] <= mem_wdata;
        end
    end

    assign s_ready        = s_ready_q;
    assign m_valid        = m_valid_q;
    assign m_data         = m_data_q;
    assign m_last         = m_valid_q && (rd_idx_q == 3'd7);
    assign busy           = (state_q != S_LOAD);
    assign mem_rdata      = mem_rdata_q;
    assign sha_input_addr = 16'(MSG_BASE);
    assign sha_hash_addr  = 16'(HASH_BASE);

endmodule

`default_nettype wire

// File: tb/tb_sha256_mem_responder.sv
// ============================================================================
//  Module      : tb_sha256_mem_responder
//  Description : Directed/random bench for sha256_mem_responder with a stub
//                hasher and array-based reference of message and digest.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sha256_mem_responder;

    localparam int NW    = 20;
    localparam int HBASE = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_ready;
    logic [31:0] s_data;
    logic        m_valid, m_ready, m_last;
    logic [31:0] m_data;
    logic        busy, error, sha_start, sha_done;
    logic [15:0] sha_input_addr, sha_hash_addr, mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata, mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] msg [NW];
    logic [31:0] dig [8];

    always #5 clk = ~clk;

    sha256_mem_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .busy           (busy),
        .error          (error),
        .sha_start      (sha_start),
        .sha_done       (sha_done),
        .sha_input_addr (sha_input_addr),
        .sha_hash_addr  (sha_hash_addr),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_sha_start", sha_start, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_error", error, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_s_ready_first", s_ready, 0);
        @(negedge clk);
        chk("rst_s_ready_after", s_ready, 1);
    endtask

    task automatic load_msg(input bit gaps);
        int k = 0;
        int cyc = 0;
        while (k < NW && cyc < 400) begin
            @(negedge clk);
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = msg[k];
            if (s_valid && s_ready) k++;
            cyc++;
        end
        chk("load_count", k, NW);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 32'hDEADBEEF;
        chk("start_pulse", sha_start, 1);
        chk("s_ready_low", s_ready, 0);
        chk("busy_start", busy, 1);
        chk("no_m_valid_load", m_valid, 0);
        @(negedge clk);
        chk("start_one_cycle", sha_start, 0);
        chk("s_ready_stays_low", s_ready, 0);
        s_valid = 1'b0;
    endtask

    task automatic read_word(input logic [15:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        mem_addr = a;
        @(negedge clk);
        chk(tag, mem_rdata, exp);
    endtask

    task automatic hash_and_drain(input bit toggle_ready);
        int idx = 0;
        int cyc = 0;
        bit hold = 1'b0;
        logic [31:0] held = '0;
        @(negedge clk);
        sha_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            mem_we    = 1'b1;
            mem_addr  = 16'(HBASE + k);
            mem_wdata = dig[k];
        end
        @(negedge clk);
        chk("busy_run", busy, 1);
        mem_addr  = 16'd5;
        mem_wdata = 32'hBAD00005;
        @(negedge clk);
        mem_addr  = 16'd40;
        mem_wdata = 32'hBAD00040;
        sha_done  = 1'b1;
        m_ready   = 1'b0;
        while (idx < 8 && cyc < 100) begin
            @(negedge clk);
            if (hold) begin
                chk("m_valid_hold", m_valid, 1);
                chk("m_data_hold", m_data, held);
            end
            m_ready = toggle_ready ? ~m_ready : 1'($urandom_range(0, 1));
            if (m_valid && m_ready) begin
                chk($sformatf("digest_%0d", idx), m_data, dig[idx]);
                chk($sformatf("m_last_%0d", idx), m_last, (idx == 7) ? 1 : 0);
                idx++;
                hold = 1'b0;
            end else begin
                hold = m_valid;
                held = m_data;
            end
            cyc++;
        end
        chk("drain_count", idx, 8);
        @(negedge clk);
        m_ready = 1'b0;
        chk("done_m_valid", m_valid, 0);
        chk("done_busy", busy, 0);
        chk("done_s_ready", s_ready, 1);
        mem_we = 1'b0;
        read_word(16'd5, msg[5], "stray_write_msg_area");
        read_word(16'(HBASE + 3), dig[3], "digest_ram_word3");
        @(negedge clk);
        mem_addr = 16'd40;
        @(negedge clk);
        n_assert++;
        assert (mem_rdata !== 32'hBAD00040) else begin
            n_fail++;
            $error("FAIL ram40_untouched observed=%0h expected=not BAD00040", mem_rdata);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        m_ready   = 1'b0;
        sha_done  = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        do_reset();
        chk("sha_input_addr", 32'(sha_input_addr), 0);
        chk("sha_hash_addr", 32'(sha_hash_addr), HBASE);

        // Pass 1: counting message, held valid, toggled ready.
        for (int i = 0; i < NW; i++) msg[i] = 32'(i);
        for (int k = 0; k < 8; k++) dig[k] = 32'hA0000000 + 32'(k);
        load_msg(1'b0);
        for (int i = 0; i < NW; i++) read_word(16'(i), msg[i], $sformatf("ram_msg_%0d", i));
        read_word(16'd70, 32'd0, "read_beyond_depth");
        repeat (120) @(negedge clk);
        chk("arm_wait_error", error, 0);
        chk("arm_wait_busy", busy, 1);
        chk("arm_wait_m_valid", m_valid, 0);
        hash_and_drain(1'b1);

        // Pass 2: random message, reset while the hasher is running.
        for (int i = 0; i < NW; i++) msg[i] = $urandom;
        load_msg(1'b1);
        @(negedge clk);
        sha_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_we    = 1'b1;
            mem_addr  = 16'(HBASE + k);
            mem_wdata = $urandom;
        end
        mem_we = 1'b0;
        sha_done = 1'b1;
        do_reset();

        // Pass 3: fresh random load and digest with random ready.
        for (int i = 0; i < NW; i++) msg[i] = $urandom;
        for (int k = 0; k < 8; k++) dig[k] = $urandom;
        load_msg(1'b1);
        read_word(16'd7, msg[7], "pass3_ram_msg_7");
        read_word(16'd19, msg[19], "pass3_ram_msg_19");
        hash_and_drain(1'b0);
        chk("final_error", error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
